// File: rtl/fmdll_pkg.sv
// Shared types and constants for the FMDLL divider phase sequencer.
package fmdll_pkg;

    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 6;

    localparam logic [1:0] PH_C2 = 2'b01;
    localparam logic [1:0] PH_C4 = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

endpackage

// File: rtl/fmdll_frac_acc.sv
// First-order fractional accumulator; DIV_M is the registered carry of each period step.
module fmdll_frac_acc
    import fmdll_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clr,
    input  logic [FRAC_W-1:0] frac,
    output logic              div_m
);

    logic [FRAC_W-1:0] acc_q;
    logic              div_m_q;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, frac};
    assign div_m = div_m_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            div_m_q <= 1'b0;
        end else if (clr) begin
            acc_q   <= '0;
            div_m_q <= 1'b0;
        end else if (step) begin
            acc_q   <= sum[FRAC_W-1:0];
            div_m_q <= sum[FRAC_W];
        end
    end

endmodule

// File: rtl/fmdll_div_seq.sv
// FMDLL divider phase sequencer: clk2/clk4 phases, mode/modulus selects and
// per-frame hold-event counting with a shadowed, frame-aligned config.
module fmdll_div_seq
    import fmdll_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              m_in,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic [CNT_W-1:0]  n_int_in,
    output logic              clk2,
    output logic              clk4,
    output logic              M,
    output logic              DIV_M,
    output logic              frame_tick,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic              cfg_pend,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            st_q, st_d;
    logic [1:0]        ph_q, ph_d;
    logic [CNT_W-1:0]  pcnt_q, hcnt_q, hold_q, hcnt_inc;
    logic              tick_q;
    logic              m_q, pend_m_q, cfg_pend_q;
    logic [FRAC_W-1:0] frac_q, pend_frac_q;
    logic [CNT_W-1:0]  n_q, pend_n_q, n_in_fix;
    logic              active, hold_ev, period_end, frame_end;
    logic              idle_load, apply_cfg, acc_clr, div_m;

    always_comb begin
        active     = (st_q != StIdle);
        hold_ev    = active && (m_q ? (ph_q == 2'd2) : (ph_q == 2'd3 && !div_m));
        period_end = active && (ph_q == 2'd3);
        frame_end  = period_end && (pcnt_q == n_q - CntOne);
        idle_load  = load && (st_q == StIdle);
        apply_cfg  = frame_end && cfg_pend_q;
        acc_clr    = idle_load || apply_cfg;
        hcnt_inc   = (hold_ev && hcnt_q != CntMax) ? hcnt_q + CntOne : hcnt_q;
        n_in_fix   = (n_int_in == '0) ? CntOne : n_int_in;
    end

    // Leaving RUN/STOP only happens at the period boundary, so phases never glitch.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle: if (en) st_d = StRun;
            StRun:  if (!en) st_d = (ph_q == 2'd3) ? StIdle : StStop;
            StStop: begin
                if (en) st_d = StRun;
                else if (ph_q == 2'd3) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
        ph_d = active ? ph_q + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= StIdle;
            ph_q <= 2'd0;
        end else begin
            st_q <= st_d;
            ph_q <= ph_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            hcnt_q <= '0;
            hold_q <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= frame_end;
            if (frame_end) begin
                pcnt_q <= '0;
                hcnt_q <= '0;
                hold_q <= hcnt_inc;
            end else begin
                hcnt_q <= hcnt_inc;
                if (period_end) pcnt_q <= pcnt_q + CntOne;
            end
        end
    end

    // A load coinciding with the applying frame end becomes the next pending config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q         <= 1'b0;
            frac_q      <= '0;
            n_q         <= CntOne;
            pend_m_q    <= 1'b0;
            pend_frac_q <= '0;
            pend_n_q    <= CntOne;
            cfg_pend_q  <= 1'b0;
        end else if (idle_load) begin
            m_q        <= m_in;
            frac_q     <= frac_in;
            n_q        <= n_in_fix;
            cfg_pend_q <= 1'b0;
        end else begin
            if (apply_cfg) begin
                m_q    <= pend_m_q;
                frac_q <= pend_frac_q;
                n_q    <= pend_n_q;
            end
            if (load) begin
                pend_m_q    <= m_in;
                pend_frac_q <= frac_in;
                pend_n_q    <= n_in_fix;
                cfg_pend_q  <= 1'b1;
            end else if (apply_cfg) begin
                cfg_pend_q <= 1'b0;
            end
        end
    end

    fmdll_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (period_end),
        .clr   (acc_clr),
        .frac  (frac_q),
        .div_m (div_m)
    );

    assign clk2       = (ph_q & PH_C2) != 2'b00;
    assign clk4       = (ph_q & PH_C4) != 2'b00;
    assign M          = m_q;
    assign DIV_M      = div_m;
    assign frame_tick = tick_q;
    assign hold_cnt   = hold_q;
    assign cfg_pend   = cfg_pend_q;
    assign busy       = active;

endmodule

// File: doc/fmdll_div_seq.md
Name: fmdll_div_seq

Overview:
- Phase sequencer for the FMDLL divider. It generates the glitch-free clk2/clk4 phase pair, the mode select M and the modulus select DIV_M that feed the hold-control gating.
- DIV_M is driven by a first-order fractional accumulator, one update per clk4 period.
- The block also counts, per frame, the hold events the downstream gate produces, so firmware and the bench can check the effective divide ratio.

Parameters:
- FRAC_W, 8, fraction width; DIV_M duty per period = frac/2^FRAC_W.
- CNT_W, 6, width of n_int and hold_cnt.

Ports:
- clk  input  1  sequencer clock; one clk4 period = 4 clk cycles.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request.
- load  input  1  one-cycle strobe; captures m_in/frac_in/n_int_in into a pending buffer.
- m_in  input  1  mode select to apply.
- frac_in  input  FRAC_W  fraction to apply.
- n_int_in  input  CNT_W  frame length in clk4 periods; 0 is treated as 1.
- clk2  output  1  divided phase, ph[0].
- clk4  output  1  divided phase, ph[1].
- M  output  1  active mode select (shadow register).
- DIV_M  output  1  modulus select, held for one full clk4 period.
- frame_tick  output  1  one-clk pulse at frame end.
- hold_cnt  output  CNT_W  hold events in the last completed frame.
- cfg_pend  output  1  pending config not yet applied.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: all registers 0.
  - Outputs: clk2=clk4=M=DIV_M=frame_tick=cfg_pend=busy=0, hold_cnt=0.
  - Internal: ph=0, acc=0, pcnt=0, hcnt=0; shadow m=0, frac=0, n=1.
- FSM states: IDLE, RUN, STOP.
  - IDLE -> RUN when en=1. The first RUN cycle has ph=0.
  - RUN -> STOP when en=0 while ph!=3.
  - RUN -> IDLE when en=0 while ph=3.
  - STOP: the current period completes. At ph=3 go to IDLE, with ph returning to 0 and both phases low.
  - en=1 during STOP returns to RUN with no phase discontinuity.
  - acc, pcnt and hcnt are retained across IDLE.
- Phase counter: ph increments by 1 per clk in RUN/STOP and wraps 3 -> 0. Sequence of (clk2, clk4): (0,0), (1,0), (0,1), (1,1). Outputs come directly from register bits.
- Hold event, evaluated each clk in RUN/STOP:
  - M=0: ph=3 and DIV_M=0.
  - M=1: ph=2.
  - Exactly one candidate per period. hcnt increments on each event and saturates at 2^CNT_W-1.
- Period end (ph=3 -> 0 edge):
  - {carry, acc} <= acc + frac, an FRAC_W+1 bit sum.
  - DIV_M <= carry.
  - pcnt <= pcnt+1.
- Frame end (period end with pcnt = n-1):
  - pcnt <= 0.
  - hold_cnt <= hcnt including the current event; hcnt <= 0.
  - frame_tick = 1 for the next clk.
  - If cfg_pend: apply shadow m/frac/n, clear acc and DIV_M to 0, clear cfg_pend.
- Config loading:
  - In IDLE, load applies immediately: shadow updated, acc=0, cfg_pend stays 0.
  - load while a config is pending overwrites it (last write wins).
  - load in the same cycle as the frame end that applies a pending config: the new values become pending.
- Edge cases:
  - frac=0: DIV_M is never set.
  - Maximum frac (2^FRAC_W-1): DIV_M set in all but one period per 2^FRAC_W.
- rst_n asserted mid-operation: immediate return to reset values. There is no partial-period completion.

Decomposition:
- Package fmdll_pkg:
  - state enum (IDLE, RUN, STOP).
  - phase encodings PH_C2 = 2'b01, PH_C4 = 2'b10.
  - default FRAC_W/CNT_W.
- Sub-module fmdll_frac_acc: accumulator plus DIV_M register, with ports clk, rst_n, step, clr, frac, div_m.
- FSM, phase counter, frame counting and shadow config stay in the top level.

Test Plan:
- Reset: hold rst_n=0 with en=1 -> all outputs 0. Release -> clk2/clk4 sequence (0,0),(1,0),(0,1),(1,1) repeats every 4 clk.
- load M=0, frac=64, n_int=8 in IDLE, then en=1:
  - frame 1: DIV_M high in period 5 only, hold_cnt=7.
  - frames 2 and 3: DIV_M in periods 1 and 5 of each, hold_cnt=6.
- M=1, frac=200, n_int=5 -> hold_cnt=5 every frame regardless of DIV_M. frame_tick period = 20 clk.
- Mid-frame reconfiguration: load frac=128 during period 3 of an 8-period frame.
  - cfg_pend=1 until frame end.
  - New config takes effect at frame end: acc=0, DIV_M=0.
  - DIV_M then high every second period.
- en dropped at ph=1 -> STOP, phases complete (0,1),(1,1), then IDLE with clk2=clk4=0 and busy=0. Re-enable resumes with ph=0, pcnt retained.
- Boundaries: n_int=0 -> frame of 1 period, frame_tick every 4 clk. frac=0 -> DIV_M never set. rst_n pulsed at ph=2 -> asynchronous clear observed in the same cycle.
